// File: rtl/pc_unit.sv
// Program-counter stage: stall hold, redirect, sequential increment and call/return prediction.
// Optional return-address stack enabled by defining PC_RAS_EN; without it calls are plain jumps.
module pc_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            call_valid,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ret_miss,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] r_pc;
    logic            r_retMiss;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pcPlus;
    logic [XLEN-1:0] w_pcNext;
    logic            w_misNext;
    logic            w_missNext;

    assign w_pcPlus = r_pc + STEP;

`ifdef PC_RAS_EN
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    // r_ptr is the next free slot; the top entry sits one below it, wrapping circularly
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;

    logic [PW-1:0]   w_topIdx;
    logic [XLEN-1:0] w_top;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_swap;

    assign w_topIdx = r_ptr - 1'b1;
    assign w_top    = r_ras[w_topIdx];
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(RAS_DEPTH));
`endif

    always_comb begin
        w_pcNext   = w_pcPlus;
        w_misNext  = 1'b0;
        w_missNext = 1'b0;
`ifdef PC_RAS_EN
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_swap     = 1'b0;
`endif
        if (redirect_valid) begin
            w_pcNext  = redirect_pc & ALIGN_MASK;
            w_misNext = |(redirect_pc & ~ALIGN_MASK);
        end else if (stall) begin
            w_pcNext = r_pc;
`ifdef PC_RAS_EN
        end else if (call_valid && ret_valid && !w_empty) begin
            w_pcNext = w_top;
            w_swap   = 1'b1;
        end else if (call_valid) begin
            w_pcNext = call_target & ALIGN_MASK;
            w_push   = 1'b1;
        end else if (ret_valid) begin
            if (!w_empty) begin
                w_pcNext = w_top;
                w_pop    = 1'b1;
            end else begin
                w_missNext = 1'b1;
            end
`else
        end else if (call_valid) begin
            w_pcNext = call_target & ALIGN_MASK;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_VECTOR;
            r_retMiss    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pcNext;
            r_retMiss    <= w_missNext;
            r_misaligned <= w_misNext;
        end
    end

`ifdef PC_RAS_EN
    // On overflow the pointer keeps advancing, silently overwriting the oldest entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (!w_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_pcPlus;
        end else if (w_swap) begin
            r_ras[w_topIdx] <= w_pcPlus;
        end
    end

    assign ras_empty = w_empty;
    assign ras_full  = w_full;
`else
    logic w_unusedRet;
    assign w_unusedRet = ret_valid;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
`endif

    assign pc_out     = r_pc;
    assign pc_plus    = w_pcPlus;
    assign ret_miss   = r_retMiss;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations plus
// randomized control traffic compared every cycle against a queue-based model.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h100;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        call_valid = 1'b0;
    logic [31:0] call_target = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ret_miss;
    logic        misaligned;

    int nVec = 0;
    int nMis = 0;
    bit checkOn = 1'b0;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .INSTR_BYTES(4), .RAS_DEPTH(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .call_valid(call_valid), .call_target(call_target), .ret_valid(ret_valid),
        .pc_out(pc_out), .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
        .ret_miss(ret_miss), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    // Reference model: PC plus a return stack held as a queue (back = top, capped at 4)
    logic [31:0] mPc = RV;
    logic [31:0] mPlus;
    logic [31:0] mRas[$];
    logic        mMiss = 1'b0;
    logic        mMisal = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mPc = RV;
            mRas.delete();
            mMiss = 1'b0;
            mMisal = 1'b0;
        end else begin
            mPlus = mPc + 32'd4;
            mMiss = 1'b0;
            mMisal = 1'b0;
            if (redirect_valid) begin
                mPc = {redirect_pc[31:2], 2'b00};
                mMisal = (redirect_pc % 4) != 0;
            end else if (stall) begin
                mPc = mPc;
            end else if (RAS && call_valid && ret_valid && mRas.size() > 0) begin
                mPc = mRas[mRas.size() - 1];
                mRas[mRas.size() - 1] = mPlus;
            end else if (call_valid) begin
                if (RAS) begin
                    if (mRas.size() == 4) void'(mRas.pop_front());
                    mRas.push_back(mPlus);
                end
                mPc = {call_target[31:2], 2'b00};
            end else if (RAS && ret_valid) begin
                if (mRas.size() > 0) begin
                    mPc = mRas.pop_back();
                end else begin
                    mPc = mPlus;
                    mMiss = 1'b1;
                end
            end else begin
                mPc = mPlus;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checkOn) begin
            checkOutput("pc_out", pc_out, mPc);
            checkOutput("pc_plus", pc_plus, mPc + 32'd4);
            checkOutput("ras_empty", 32'(ras_empty), 32'(mRas.size() == 0));
            checkOutput("ras_full", 32'(ras_full), 32'(mRas.size() == 4));
            checkOutput("ret_miss", 32'(ret_miss), 32'(mMiss));
            checkOutput("misaligned", 32'(misaligned), 32'(mMisal));
        end
    end

    // Drive one cycle of controls, then return just after the edge that consumed them
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic st,
                                 input logic cv, input logic [31:0] ct, input logic rt);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        call_valid     = cv;
        call_target    = ct;
        ret_valid      = rt;
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 checkOn = 1'b1;
        checkOutput("reset pc", pc_out, 32'h100);
        checkOutput("reset ras_empty", 32'(ras_empty), 32'd1);
        #3 reset_n = 1'b1;

        idle(); checkOutput("run1", pc_out, 32'h104);
        idle(); checkOutput("run2", pc_out, 32'h108);
        applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redirect", pc_out, 32'h3000);

        // Asynchronous reset in the middle of a cycle
        redirect_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1 checkOutput("midrun reset pc", pc_out, 32'h100);
        checkOutput("midrun reset miss", 32'(ret_miss), 32'd0);
        #2 reset_n = 1'b1;
        idle(); checkOutput("after reset 1", pc_out, 32'h104);
        idle(); checkOutput("after reset 2", pc_out, 32'h108);
        idle(); checkOutput("after reset 3", pc_out, 32'h10C);

        // Stall hold, then redirect overriding stall with a misaligned target
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 1'b1);
        checkOutput("stall hold 1", pc_out, 32'h10C);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stall hold 2", pc_out, 32'h10C);
        applyStimulus(1'b1, 32'h2002, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stall+redirect pc", pc_out, 32'h2000);
        checkOutput("misaligned pulse", 32'(misaligned), 32'd1);
        idle();
        checkOutput("misaligned clears", 32'(misaligned), 32'd0);
        checkOutput("after redirect seq", pc_out, 32'h2004);

        // Call then return
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0);
        checkOutput("call pc", pc_out, 32'h800);
        checkOutput("call ras_empty", 32'(ras_empty), 32'(!RAS));
        idle(); idle();
        checkOutput("call seq", pc_out, 32'h808);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ret pc", pc_out, RAS ? 32'h44 : 32'h80C);
        checkOutput("ret ras_empty", 32'(ras_empty), 32'd1);

        // Five nested calls into a four-entry stack
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 16), 1'b0);
        end
        checkOutput("overflow pc", pc_out, 32'h50);
        checkOutput("overflow full", 32'(ras_full), 32'(RAS));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("overflow ret", pc_out,
                        RAS ? 32'(32'h44 - i * 16) : 32'(32'h54 + i * 4));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("empty ret pc", pc_out, RAS ? 32'h18 : 32'h64);
        checkOutput("empty ret miss", 32'(ret_miss), 32'(RAS));
        idle();
        checkOutput("ret miss clears", 32'(ret_miss), 32'd0);

        // Simultaneous call and return swap the top entry
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1);
        checkOutput("call+ret pc", pc_out, RAS ? 32'h44 : 32'h300);
        checkOutput("call+ret miss", 32'(ret_miss), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("swapped top", pc_out, RAS ? 32'h904 : 32'h304);
        checkOutput("swapped empty", 32'(ras_empty), 32'd1);

        // Address wrap
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap pre", pc_plus, 32'h0);
        idle();
        checkOutput("wrap", pc_out, 32'h0);
        checkOutput("wrap no flag", 32'(misaligned), 32'd0);

        // Randomized control traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 10) == 0, $urandom, ($urandom % 5) == 0,
                          ($urandom % 3) == 0, $urandom, ($urandom % 3) == 0);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
